// File: rtl/tp_probe_mux.sv
// Test-point driver: registered group mux onto the TP bank with a one-shot trigger/freeze.
// Optional per-bit pulse stretching is built only when TP_PULSE_STRETCH_EN is defined.
module tp_probe_mux #(
  parameter int              TP_W     = 16,
  parameter int              N_GRP    = 4,
  parameter int              SEL_W    = 2,
  parameter int              IDX_W    = 4,
  parameter int              DEF_SEL  = 0,
  parameter logic [TP_W-1:0] DIR_MASK = '0,
  parameter int              HOLD_CYC = 1024,
  parameter int              STR_LEN  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_GRP*TP_W-1:0] PROBES,
  input  logic                  SEL_WE,
  input  logic [SEL_W-1:0]      SEL_DIN,
  input  logic                  ARM,
  input  logic                  DISARM,
  input  logic [IDX_W-1:0]      TRG_IDX,
  output logic [TP_W-1:0]       TP_OUT,
  output logic [TP_W-1:0]       TP_DIR,
  output logic [1:0]            TP_STATE,
  output logic [15:0]           TRG_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam int HOLD_W = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD_CYC > 0) ? HOLD_W'(HOLD_CYC - 1) : '0;

  logic [SEL_W-1:0]  sel_q;
  logic [TP_W-1:0]   s1_q;
  logic [TP_W-1:0]   s1_d;
  logic [TP_W-1:0]   prev_q;
  logic [TP_W-1:0]   out_q;
  logic [TP_W-1:0]   out_d;
  logic [TP_W-1:0]   rise;
  logic              trig_hit;
  state_t            state_q;
  logic [15:0]       trg_cnt_q;
  logic [HOLD_W-1:0] hold_q;

  // Out-of-range selects fall through the loop and yield zero.
  always_comb begin
    s1_d = '0;
    for (int g = 0; g < N_GRP; g++) begin
      if (sel_q == SEL_W'(g)) s1_d = PROBES[g*TP_W +: TP_W];
    end
  end

  assign rise = s1_q & ~prev_q;

  always_comb begin
    trig_hit = 1'b0;
    for (int i = 0; i < TP_W; i++) begin
      if (TRG_IDX == IDX_W'(i)) trig_hit = rise[i];
    end
  end

`ifdef TP_PULSE_STRETCH_EN
  localparam int CNT_W = (STR_LEN > 2) ? $clog2(STR_LEN) : 1;
  localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STR_LEN - 1);

  logic [CNT_W-1:0] str_cnt_q [TP_W];
  logic [TP_W-1:0]  str_act;

  always_comb begin
    str_act = '0;
    for (int i = 0; i < TP_W; i++) str_act[i] = (str_cnt_q[i] != '0);
  end

  assign out_d = s1_q | str_act;

  // A group switch clears the counters so stale stretches never leak into the new group.
  always_ff @(posedge CLK) begin
    if (RST || SEL_WE) begin
      for (int i = 0; i < TP_W; i++) str_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < TP_W; i++) begin
        if (rise[i])                   str_cnt_q[i] <= STR_LOAD;
        else if (str_cnt_q[i] != '0)   str_cnt_q[i] <= str_cnt_q[i] - 1'b1;
      end
    end
  end
`else
  assign out_d = s1_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_q     <= SEL_W'(DEF_SEL);
      s1_q      <= '0;
      prev_q    <= '0;
      out_q     <= '0;
      state_q   <= ST_IDLE;
      trg_cnt_q <= '0;
      hold_q    <= '0;
    end else begin
      if (SEL_WE) sel_q <= SEL_DIN;
      s1_q   <= s1_d;
      prev_q <= s1_q;
      // The trigger edge itself still loads out_q, so the frozen word is f(s1) of that cycle.
      if (state_q != ST_FROZEN) out_q <= out_d;

      case (state_q)
        ST_IDLE: begin
          if (!DISARM && ARM) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (DISARM) begin
            state_q <= ST_IDLE;
          end else if (trig_hit) begin
            state_q <= ST_FROZEN;
            hold_q  <= HOLD_LOAD;
            if (trg_cnt_q != 16'hFFFF) trg_cnt_q <= trg_cnt_q + 16'd1;
          end
        end
        ST_FROZEN: begin
          if (DISARM) begin
            state_q <= ST_IDLE;
          end else if (HOLD_CYC != 0) begin
            if (hold_q == '0) state_q <= ST_IDLE;
            else              hold_q  <= hold_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TP_OUT   = out_q;
  assign TP_DIR   = DIR_MASK;
  assign TP_STATE = state_q;
  assign TRG_CNT  = trg_cnt_q;

endmodule

// File: tb/tb_tp_probe_mux.sv
// Directed bench for tp_probe_mux: instance A (4 groups, 1024-cycle hold) and
// instance B (3 groups, hold-until-disarm, default group 1).
module tb_tp_probe_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_probes;
  logic        a_sel_we, a_arm, a_disarm;
  logic [1:0]  a_sel_din;
  logic [3:0]  a_trg_idx;
  logic [15:0] a_out, a_dir, a_cnt;
  logic [1:0]  a_state;

  logic [47:0] b_probes;
  logic        b_sel_we, b_arm, b_disarm;
  logic [1:0]  b_sel_din;
  logic [4:0]  b_trg_idx;
  logic [15:0] b_out, b_dir, b_cnt;
  logic [1:0]  b_state;

  int n_chk = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  tp_probe_mux #(
    .TP_W(16), .N_GRP(4), .SEL_W(2), .IDX_W(4), .DEF_SEL(0),
    .DIR_MASK(16'h00FF), .HOLD_CYC(1024), .STR_LEN(8)
  ) dut_a (
    .CLK(clk), .RST(rst), .PROBES(a_probes), .SEL_WE(a_sel_we), .SEL_DIN(a_sel_din),
    .ARM(a_arm), .DISARM(a_disarm), .TRG_IDX(a_trg_idx), .TP_OUT(a_out), .TP_DIR(a_dir),
    .TP_STATE(a_state), .TRG_CNT(a_cnt)
  );

  tp_probe_mux #(
    .TP_W(16), .N_GRP(3), .SEL_W(2), .IDX_W(5), .DEF_SEL(1),
    .DIR_MASK(16'hF00F), .HOLD_CYC(0), .STR_LEN(8)
  ) dut_b (
    .CLK(clk), .RST(rst), .PROBES(b_probes), .SEL_WE(b_sel_we), .SEL_DIN(b_sel_din),
    .ARM(b_arm), .DISARM(b_disarm), .TRG_IDX(b_trg_idx), .TP_OUT(b_out), .TP_DIR(b_dir),
    .TP_STATE(b_state), .TRG_CNT(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Arm, then a one-cycle pulse on group g; returns just after the trigger edge.
  task automatic trig_a(input int g, input logic [15:0] base, input logic [15:0] pulsed);
    a_arm = 1'b1;
    tick(1);
    a_arm = 1'b0;
    a_probes[g*16 +: 16] = pulsed;
    tick(1);
    a_probes[g*16 +: 16] = base;
    tick(1);
  endtask

  task automatic disarm_a();
    a_disarm = 1'b1;
    tick(1);
    a_disarm = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_probes = {16'hFFFF, 16'hA5C3, 16'h0F0F, 16'h1234};
    b_probes = {16'h7777, 16'hBEEF, 16'h0100};
    a_sel_we = 0; a_sel_din = 0; a_arm = 0; a_disarm = 0; a_trg_idx = 0;
    b_sel_we = 0; b_sel_din = 0; b_arm = 0; b_disarm = 0; b_trg_idx = 0;
    tick(2);
    chk("rst_a_out", a_out, 16'h0000);
    chk("rst_a_state", a_state, 2'd0);
    chk("rst_a_cnt", a_cnt, 16'h0000);
    chk("rst_a_dir", a_dir, 16'h00FF);
    chk("rst_b_out", b_out, 16'h0000);
    rst = 1'b0;
    tick(10);
    chk("def_sel_a", a_out, 16'h1234);
    chk("def_sel_b", b_out, 16'hBEEF);
    chk("dir_b", b_dir, 16'hF00F);

    // Group select: 1 cycle to load the register, 2 through the pipeline.
    a_sel_we = 1; a_sel_din = 2'd2;
    tick(1);
    a_sel_we = 0;
    tick(1);
    chk("sel_a_lat2", a_out, 16'h1234);
    tick(1);
    chk("sel_a_grp2", a_out, 16'hA5C3);

    b_sel_we = 1; b_sel_din = 2'd3;
    tick(1);
    b_sel_we = 0;
    tick(2);
    chk("sel_b_oob", b_out, 16'h0000);
    b_sel_we = 1; b_sel_din = 2'd0;
    tick(1);
    b_sel_we = 0;
    tick(2);
    chk("sel_b_grp0", b_out, 16'h0100);

    // Trigger on bit 5 with the 1024-cycle hold.
    a_trg_idx = 4'd5;
    a_arm = 1'b1;
    tick(1);
    a_arm = 1'b0;
    chk("armed_a", a_state, 2'd1);
    a_probes[32 +: 16] = 16'hA5E3;
    tick(1);
    a_probes[32 +: 16] = 16'hA5C3;
    tick(1);
    chk("trig_state", a_state, 2'd2);
    chk("trig_cnt", a_cnt, 16'd1);
    chk("trig_out", a_out, 16'hA5E3);
    tick(20);
    chk("frozen_out", a_out, 16'hA5E3);
    tick(1003);
    chk("hold_last", a_state, 2'd2);
    tick(1);
    chk("hold_exit", a_state, 2'd0);
    chk("hold_exit_out", a_out, 16'hA5E3);
    tick(1);
    chk("live_after", a_out, 16'hA5C3);

    // ARM with DISARM -> IDLE; DISARM beats a trigger edge.
    a_arm = 1; a_disarm = 1;
    tick(1);
    chk("arm_disarm", a_state, 2'd0);
    a_disarm = 0;
    tick(1);
    a_arm = 0;
    chk("rearm", a_state, 2'd1);
    a_probes[32 +: 16] = 16'hA5E3;
    tick(1);
    a_probes[32 +: 16] = 16'hA5C3;
    a_disarm = 1;
    tick(1);
    a_disarm = 0;
    chk("disarm_trig_st", a_state, 2'd0);
    chk("disarm_trig_cnt", a_cnt, 16'd1);

    // ARM coinciding with an edge in IDLE arms only.
    a_probes[32 +: 16] = 16'hA5E3;
    tick(1);
    a_arm = 1;
    a_probes[32 +: 16] = 16'hA5C3;
    tick(1);
    a_arm = 0;
    chk("arm_edge", a_state, 2'd1);
    tick(2);
    chk("arm_edge_hold", a_state, 2'd1);
    disarm_a();
    chk("arm_edge_clr", a_state, 2'd0);

    // Select change during freeze leaves the frozen word until exit.
    trig_a(2, 16'hA5C3, 16'hA5E3);
    chk("fz2_state", a_state, 2'd2);
    chk("fz2_cnt", a_cnt, 16'd2);
    a_sel_we = 1; a_sel_din = 2'd1;
    tick(1);
    a_sel_we = 0;
    tick(5);
    chk("fz2_sel_out", a_out, 16'hA5E3);
    disarm_a();
    chk("fz2_exit", a_state, 2'd0);
    chk("fz2_exit_out", a_out, 16'hA5E3);
    tick(1);
    chk("fz2_grp1", a_out, 16'h0F0F);

    // Pulse stretch on B bit 0.
    for (int k = 0; k < 12; k++) begin
`ifdef TP_PULSE_STRETCH_EN
      exp_q.push_back(16'h0100 | {15'd0, (k >= 1 && k <= 8)});
`else
      exp_q.push_back(16'h0100 | {15'd0, (k == 1)});
`endif
    end
    b_probes[0 +: 16] = 16'h0101;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (k == 0) b_probes[0 +: 16] = 16'h0100;
      chk($sformatf("stretch_%0d", k), b_out, exp_q.pop_front());
    end

    // B: out-of-range trigger index never fires; HOLD_CYC=0 holds until DISARM.
    b_trg_idx = 5'd20;
    b_arm = 1;
    tick(1);
    b_arm = 0;
    b_probes[0 +: 16] = 16'h0101;
    tick(1);
    b_probes[0 +: 16] = 16'h0100;
    tick(2);
    chk("idx_oob", b_state, 2'd1);
    b_trg_idx = 5'd0;
    tick(10);
    b_probes[0 +: 16] = 16'h0101;
    tick(1);
    b_probes[0 +: 16] = 16'h0100;
    tick(1);
    chk("b_trig", b_state, 2'd2);
    chk("b_trig_out", b_out, 16'h0101);
    tick(50);
    chk("b_hold", b_state, 2'd2);
    chk("b_hold_out", b_out, 16'h0101);
    b_arm = 1;
    tick(1);
    b_arm = 0;
    chk("b_arm_ign", b_state, 2'd2);
    b_disarm = 1;
    tick(1);
    b_disarm = 0;
    chk("b_disarm", b_state, 2'd0);
    chk("b_cnt", b_cnt, 16'd1);
    tick(1);
    chk("b_live", b_out, 16'h0100);

    // Counter saturation, then reset mid-freeze.
    dut_a.trg_cnt_q = 16'hFFFE;
    tick(1);
    trig_a(1, 16'h0F0F, 16'h0F2F);
    chk("sat_to_max", a_cnt, 16'hFFFF);
    disarm_a();
    trig_a(1, 16'h0F0F, 16'h0F2F);
    chk("sat_state", a_state, 2'd2);
    chk("sat_hold", a_cnt, 16'hFFFF);
    rst = 1'b1;
    tick(1);
    chk("rstfz_state", a_state, 2'd0);
    chk("rstfz_cnt", a_cnt, 16'h0000);
    chk("rstfz_out", a_out, 16'h0000);
    chk("rstfz_dir", a_dir, 16'h00FF);
    rst = 1'b0;
    tick(3);
    chk("rstfz_live", a_out, 16'h1234);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
